zle_xc9_fsm: RTL and testbench
==============================

ZLE_XC9_FSM -- requirements
Module: zle_xc9_fsm

Interface
REQ-001 clock  in  1  single clock; all state updates on posedge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 i_empty  in  1  input stream i has no token this cycle.
REQ-004 o_full  in  1  output stream o cannot accept a token this cycle.
REQ-005 f_start_i_eq_0  in  1  datapath flag: head of i equals 0 (START context).
REQ-006 f_zeros_i_eq_0  in  1  datapath flag: head of i equals 0 (ZEROS context).
REQ-007 f_zeros_t_cnt_eq_15  in  1  datapath flag: run counter equals 15.
REQ-008 sel_o_d  out  1  output-data mux select: 0=START_E (literal), 1=ZEROS_T_T (run token).
REQ-009 sel_cnt  out  2  counter mux select: 0=HOLD, 1=LOAD1, 2=CLEAR, 3=INCR.
REQ-010 i_b  out  1  input not-consume: 1=hold history register and do not pop i.
REQ-011 o_we  out  1  write strobe into output stream o.
REQ-012 state  out  2  current state: 0=START, 1=ZEROS, 2=PENDING.
REQ-013 tok_count  out  16  count of tokens written to o, saturating.

Function
REQ-014 States SHALL be START, ZEROS and PENDING; encoding 3 is illegal and SHALL transition to START on the next edge with stall outputs.
REQ-015 The block SHALL drive the stall vector (i_b=1, o_we=0, sel_cnt=HOLD, sel_o_d=0) whenever the current state does not fire.
REQ-016 All outputs except state and tok_count SHALL be combinational from state, flags, i_empty and o_full. They SHALL not be registered, so each select is valid in the same cycle it is used.
REQ-017 START, !i_empty, f_start_i_eq_0: consume (i_b=0), sel_cnt=LOAD1, o_we=0, next ZEROS; o_full is ignored.
REQ-018 START, !i_empty, !f_start_i_eq_0, !o_full: consume, o_we=1, sel_o_d=0, sel_cnt=HOLD, stay START.
REQ-019 ZEROS, !i_empty, f_zeros_i_eq_0, !f_zeros_t_cnt_eq_15: consume, sel_cnt=INCR, o_we=0, stay ZEROS; o_full is ignored.
REQ-020 ZEROS, !i_empty, f_zeros_i_eq_0, f_zeros_t_cnt_eq_15, !o_full: consume, o_we=1, sel_o_d=1, sel_cnt=CLEAR, stay ZEROS.
REQ-021 ZEROS, !i_empty, !f_zeros_i_eq_0, !o_full: do not consume (i_b=1), o_we=1, sel_o_d=1, sel_cnt=CLEAR, next PENDING.
REQ-022 PENDING, !i_empty, !o_full: consume, o_we=1, sel_o_d=0, sel_cnt=HOLD, next START.
REQ-023 Any firing rule above that writes o SHALL stall entirely when o_full=1. No partial consume and no counter update are permitted.
REQ-024 i_empty=1 SHALL stall every state, including PENDING, regardless of o_full.
REQ-025 tok_count SHALL increment by 1 on every cycle with o_we=1 and SHALL hold at 16'hFFFF once reached.
REQ-026 At most one transition and one output token SHALL occur per cycle. A simultaneous i_empty deassert and o_full assert SHALL be resolved only by REQ-017..024.

Reset
REQ-027 reset=0 SHALL immediately force state=START and tok_count=0, with the stall vector on all select outputs.
REQ-028 Reset asserted mid-run (ZEROS or PENDING) SHALL discard the pending run. No token SHALL be emitted on or after the reset release edge until a new rule fires.
REQ-029 The datapath counter reset (cnt=0) is owned by the datapath; the FSM SHALL not rely on any other reset state of it.

Structure
REQ-030 State encodings, sel_o_d codes (START_E=0, ZEROS_T_T=1) and sel_cnt codes (HOLD/LOAD1/CLEAR/INCR) SHALL live in a shared zle package used by both FSM and datapath.
REQ-031 The saturating tok_count SHALL be one sub-module, sat_counter16 (inc, clear-on-reset, count).
REQ-032 A top-level zle_xc9 wrapper outside this block SHALL connect the FSM and datapath flag-for-flag.

Verification
REQ-033 Reset, then i=5 with o_full=0 -> cycle 1: o_we=1, sel_o_d=0, i_b=0, state stays START, tok_count=1.
REQ-034 Input stream 0,0,0,7 with o never full -> sel_cnt sequence LOAD1, INCR, INCR, then CLEAR with i_b=1, o_we=1 and state PENDING. The next cycle gives o_we=1, sel_o_d=0, i_b=0, state START, tok_count=2.
REQ-035 Sixteen zeros with f_zeros_t_cnt_eq_15 raised on the 16th -> that cycle gives o_we=1, sel_o_d=1, sel_cnt=CLEAR, i_b=0, and state remains ZEROS.
REQ-036 In ZEROS with nonzero head and o_full=1 for 3 cycles -> stall vector for 3 cycles, then the REQ-021 response on the first o_full=0 cycle.
REQ-037 In PENDING with i_empty=1 and o_full=0 -> stall persists; reset pulse -> state=START and tok_count=0 asynchronously.
REQ-038 Force 65540 literal tokens -> tok_count reads 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/zle_pkg.sv
// Shared encodings for the zero-length-encoder control path: FSM states,
// output-data mux codes and run-counter mux codes.
package zle_pkg;

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_ZEROS   = 2'd1,
        ST_PENDING = 2'd2,
        ST_ILLEGAL = 2'd3
    } zle_state_e;

    typedef enum logic {
        SEL_O_START_E   = 1'b0,
        SEL_O_ZEROS_T_T = 1'b1
    } zle_sel_o_e;

    typedef enum logic [1:0] {
        CNT_HOLD  = 2'd0,
        CNT_LOAD1 = 2'd1,
        CNT_CLEAR = 2'd2,
        CNT_INCR  = 2'd3
    } zle_sel_cnt_e;

    localparam int unsigned TOK_W = 16;
    localparam logic [TOK_W-1:0] TOK_MAX = '1;

endpackage

// File: rtl/zle_xc9_fsm_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import zle_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [TOK_W-1:0] count_o
);

    logic [TOK_W-1:0] count_q;
    logic [TOK_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != TOK_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/zle_xc9_fsm.sv
// Control FSM of the zero-length encoder: decides per cycle whether to pop i,
// write o, and how the datapath run counter and output mux are steered.
module zle_xc9_fsm
    import zle_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_empty,
    input  logic             o_full,
    input  logic             f_start_i_eq_0,
    input  logic             f_zeros_i_eq_0,
    input  logic             f_zeros_t_cnt_eq_15,
    output logic             sel_o_d,
    output logic [1:0]       sel_cnt,
    output logic             i_b,
    output logic             o_we,
    output logic [1:0]       state,
    output logic [TOK_W-1:0] tok_count
);

    // Handshake: a token is popped from i when i_b=0 (only while !i_empty) and
    // pushed into o when o_we=1 (only while !o_full); otherwise nothing moves.

    zle_state_e   state_q;
    zle_state_e   state_d;
    zle_sel_o_e   sel_o_w;
    zle_sel_cnt_e sel_cnt_w;
    logic         i_b_w;
    logic         o_we_w;

    // Outputs stay combinational so each select is valid in the cycle it is used;
    // reset gates them directly so the stall vector appears without waiting for an edge.
    always_comb begin
        state_d   = state_q;
        sel_o_w   = SEL_O_START_E;
        sel_cnt_w = CNT_HOLD;
        i_b_w     = 1'b1;
        o_we_w    = 1'b0;
        if (state_q == ST_ILLEGAL) begin
            state_d = ST_START;
        end else if (reset && !i_empty) begin
            case (state_q)
                ST_START: begin
                    if (f_start_i_eq_0) begin
                        i_b_w     = 1'b0;
                        sel_cnt_w = CNT_LOAD1;
                        state_d   = ST_ZEROS;
                    end else if (!o_full) begin
                        i_b_w  = 1'b0;
                        o_we_w = 1'b1;
                    end
                end
                ST_ZEROS: begin
                    if (f_zeros_i_eq_0 && !f_zeros_t_cnt_eq_15) begin
                        i_b_w     = 1'b0;
                        sel_cnt_w = CNT_INCR;
                    end else if (f_zeros_i_eq_0 && !o_full) begin
                        i_b_w     = 1'b0;
                        o_we_w    = 1'b1;
                        sel_o_w   = SEL_O_ZEROS_T_T;
                        sel_cnt_w = CNT_CLEAR;
                    end else if (!f_zeros_i_eq_0 && !o_full) begin
                        // Flush the run token now; the nonzero head is replayed from PENDING.
                        o_we_w    = 1'b1;
                        sel_o_w   = SEL_O_ZEROS_T_T;
                        sel_cnt_w = CNT_CLEAR;
                        state_d   = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (!o_full) begin
                        i_b_w   = 1'b0;
                        o_we_w  = 1'b1;
                        state_d = ST_START;
                    end
                end
                default: state_d = ST_START;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter16 u_tok_cnt (
        .clk_i   (clock),
        .rst_ni  (reset),
        .inc_i   (o_we_w),
        .count_o (tok_count)
    );

    assign sel_o_d = sel_o_w;
    assign sel_cnt = sel_cnt_w;
    assign i_b     = i_b_w;
    assign o_we    = o_we_w;
    assign state   = state_q;

endmodule

// File: tb/tb_zle_xc9_fsm.sv
// Directed bench for zle_xc9_fsm: literal path, zero runs, run overflow,
// back-pressure, PENDING stall, async reset and tok_count saturation.
module tb_zle_xc9_fsm;

    logic        clock;
    logic        reset;
    logic        i_empty;
    logic        o_full;
    logic        f_start_i_eq_0;
    logic        f_zeros_i_eq_0;
    logic        f_zeros_t_cnt_eq_15;
    logic        sel_o_d;
    logic [1:0]  sel_cnt;
    logic        i_b;
    logic        o_we;
    logic [1:0]  state;
    logic [15:0] tok_count;

    int errors = 0;
    int checks = 0;

    zle_xc9_fsm dut (
        .clock               (clock),
        .reset               (reset),
        .i_empty             (i_empty),
        .o_full              (o_full),
        .f_start_i_eq_0      (f_start_i_eq_0),
        .f_zeros_i_eq_0      (f_zeros_i_eq_0),
        .f_zeros_t_cnt_eq_15 (f_zeros_t_cnt_eq_15),
        .sel_o_d             (sel_o_d),
        .sel_cnt             (sel_cnt),
        .i_b                 (i_b),
        .o_we                (o_we),
        .state               (state),
        .tok_count           (tok_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change just after a negedge; combinational outputs are then
    // sampled #1 later, well away from the next posedge.
    task automatic drive(input logic e, input logic f, input logic fs,
                         input logic fz, input logic f15);
        i_empty             = e;
        o_full              = f;
        f_start_i_eq_0      = fs;
        f_zeros_i_eq_0      = fz;
        f_zeros_t_cnt_eq_15 = f15;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({state, tok_count} !== {2'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_state: state=%0d tok=%0d required 0/0", state, tok_count);
        end
        checks++;
        if ({o_we, i_b, sel_cnt, sel_o_d} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_stall: we/ib/cnt/sel=%b required 01000", {o_we, i_b, sel_cnt, sel_o_d});
        end
        next_cycle();
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({state, tok_count, o_we} !== {2'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: state=%0d tok=%0d we=%b required 0/0/0", state, tok_count, o_we);
        end
    endtask

    task automatic test_literal();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({o_we, sel_o_d, i_b, sel_cnt} !== 5'b10000) begin
            errors++;
            $display("FAIL literal_out: we/sel/ib/cnt=%b required 10000", {o_we, sel_o_d, i_b, sel_cnt});
        end
        next_cycle();
        checks++;
        if ({state, tok_count} !== {2'd0, 16'd1}) begin
            errors++;
            $display("FAIL literal_after: state=%0d tok=%0d required 0/1", state, tok_count);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({o_we, i_b, sel_cnt} !== 4'b0100) begin
            errors++;
            $display("FAIL literal_full_stall: we/ib/cnt=%b required 0100", {o_we, i_b, sel_cnt});
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({o_we, i_b, sel_cnt} !== 4'b0100) begin
            errors++;
            $display("FAIL start_empty_stall: we/ib/cnt=%b required 0100", {o_we, i_b, sel_cnt});
        end
    endtask

    task automatic test_zero_run();
        logic [1:0] exp_cnt[3] = '{2'd1, 2'd3, 2'd3};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            else        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({sel_cnt, i_b, o_we} !== {exp_cnt[k], 2'b00}) begin
                errors++;
                $display("FAIL zero_run_%0d: cnt=%0d ib=%b we=%b required cnt=%0d ib=0 we=0",
                         k, sel_cnt, i_b, o_we, exp_cnt[k]);
            end
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({sel_cnt, i_b, o_we, sel_o_d} !== 5'b10111) begin
            errors++;
            $display("FAIL zero_run_flush: cnt/ib/we/sel=%b required 10111", {sel_cnt, i_b, o_we, sel_o_d});
        end
        next_cycle();
        checks++;
        if ({state, tok_count} !== {2'd2, 16'd1}) begin
            errors++;
            $display("FAIL zero_run_pending: state=%0d tok=%0d required 2/1", state, tok_count);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({o_we, sel_o_d, i_b, sel_cnt} !== 5'b10000) begin
            errors++;
            $display("FAIL pending_emit: we/sel/ib/cnt=%b required 10000", {o_we, sel_o_d, i_b, sel_cnt});
        end
        next_cycle();
        checks++;
        if ({state, tok_count} !== {2'd0, 16'd2}) begin
            errors++;
            $display("FAIL pending_after: state=%0d tok=%0d required 0/2", state, tok_count);
        end
    endtask

    task automatic test_run16();
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({sel_cnt, i_b, o_we} !== 4'b0100) begin
            errors++;
            $display("FAIL run16_load_full: cnt/ib/we=%b required 0100", {sel_cnt, i_b, o_we});
        end
        next_cycle();
        for (int k = 2; k <= 15; k++) begin
            drive(1'b0, (k == 5), 1'b0, 1'b1, 1'b0);
            checks++;
            if ({sel_cnt, i_b, o_we, state} !== 6'b110001) begin
                errors++;
                $display("FAIL run16_incr_%0d: cnt/ib/we/state=%b required 110001", k, {sel_cnt, i_b, o_we, state});
            end
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({o_we, sel_o_d, sel_cnt, i_b} !== 5'b11100) begin
            errors++;
            $display("FAIL run16_emit: we/sel/cnt/ib=%b required 11100", {o_we, sel_o_d, sel_cnt, i_b});
        end
        next_cycle();
        checks++;
        if ({state, tok_count} !== {2'd1, 16'd1}) begin
            errors++;
            $display("FAIL run16_after: state=%0d tok=%0d required 1/1", state, tok_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({o_we, i_b, sel_cnt, sel_o_d, state} !== 7'b0100001) begin
                errors++;
                $display("FAIL bp_stall_%0d: we/ib/cnt/sel/state=%b required 0100001", k,
                         {o_we, i_b, sel_cnt, sel_o_d, state});
            end
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({o_we, i_b, sel_cnt, sel_o_d} !== 5'b11101) begin
            errors++;
            $display("FAIL bp_release: we/ib/cnt/sel=%b required 11101", {o_we, i_b, sel_cnt, sel_o_d});
        end
        next_cycle();
        checks++;
        if ({state, tok_count} !== {2'd2, 16'd1}) begin
            errors++;
            $display("FAIL bp_after: state=%0d tok=%0d required 2/1", state, tok_count);
        end
    endtask

    task automatic test_pending_stall();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({o_we, i_b, sel_cnt} !== 4'b0100) begin
                errors++;
                $display("FAIL pend_empty_%0d: we/ib/cnt=%b required 0100", k, {o_we, i_b, sel_cnt});
            end
            next_cycle();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({o_we, i_b, state} !== 4'b0110) begin
            errors++;
            $display("FAIL pend_full: we/ib/state=%b required 0110", {o_we, i_b, state});
        end
        #2;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({state, tok_count, o_we, i_b} !== {2'd0, 16'd0, 2'b01}) begin
            errors++;
            $display("FAIL pend_async_reset: state=%0d tok=%0d we=%b ib=%b required 0/0/0/1",
                     state, tok_count, o_we, i_b);
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        next_cycle();
        checks++;
        if ({state, tok_count, o_we} !== {2'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL pend_discard: state=%0d tok=%0d we=%b required 0/0/0", state, tok_count, o_we);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 65534; k++) next_cycle();
        checks++;
        if (tok_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre: tok=%h required fffe", tok_count);
        end
        next_cycle();
        checks++;
        if (tok_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: tok=%h required ffff", tok_count);
        end
        for (int k = 0; k < 5; k++) next_cycle();
        checks++;
        if ({tok_count, o_we} !== {16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL sat_hold: tok=%h we=%b required ffff/1", tok_count, o_we);
        end
    endtask

    initial begin
        reset = 1'b1;
        i_empty = 1'b1;
        o_full = 1'b0;
        f_start_i_eq_0 = 1'b0;
        f_zeros_i_eq_0 = 1'b0;
        f_zeros_t_cnt_eq_15 = 1'b0;
        test_reset();
        test_literal();
        test_zero_run();
        test_run16();
        test_backpressure();
        test_pending_stall();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
